// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared definitions for the instruction-fetch stage: bus widths, reset
// polarity, the zero word and the fetch FSM state encoding.
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

  localparam int InstAddrBus = 32;  // pc / byte address width
  localparam int InstBus     = 32;  // assembled instruction width
  localparam int MemByteBus  = 8;   // memory read-data width (7:0)

  localparam logic RstEnable = 1'b1;

  typedef logic [InstAddrBus-1:0] addr_t;
  typedef logic [InstBus-1:0]     inst_t;
  typedef logic [MemByteBus-1:0]  byte_t;

  localparam inst_t ZeroWord = '0;

  // FETCH: issuing byte requests; DRAIN: last byte in flight;
  // HOLD: assembled instruction presented to IF/ID.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } if_state_e;

endpackage

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch stage. Reads four bytes per instruction over a byte-wide
// memory port shared with MEM (arbiter reports mem_busy_i), assembles them
// little-endian and presents pc/instruction to IF/ID. Applies decode's
// redirect and honours downstream stall. All outputs come straight from flops.
//
// Ports
//   clk                  clock, rising edge
//   rst                  synchronous reset, active high
//   stall_i              IF/ID not ready: hold the presented instruction
//   branch_flag_i        redirect request from decode (ignored while stalled)
//   branch_target_addr_i redirect pc
//   mem_busy_i           arbiter serving MEM this cycle: fetch request not served
//   mem_din_i            read byte, valid the cycle after a served request
//   if_req_o             fetch read request
//   if_addr_o            byte address of the request
//   pc_o                 address of the presented instruction
//   inst_o               presented instruction
//   inst_valid_o         pc_o / inst_o valid
// -----------------------------------------------------------------------------
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_addr_i,
  input  logic                   mem_busy_i,
  input  logic [MemByteBus-1:0]  mem_din_i,
  output logic                   if_req_o,
  output logic [InstAddrBus-1:0] if_addr_o,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
  output logic                   inst_valid_o
);

  if_state_e  state_q, state_d;
  addr_t      pc_q, pc_d;
  logic [1:0] req_cnt_q, req_cnt_d;   // next byte to request
  logic [1:0] rcv_cnt_q, rcv_cnt_d;   // next byte lane to fill
  logic       served_q, served_d;     // qualifies mem_din_i this cycle
  inst_t      inst_buf_q, inst_buf_d;

  logic  if_req_q, if_req_d;
  addr_t if_addr_q, if_addr_d;
  addr_t pc_o_q, pc_o_d;
  inst_t inst_q, inst_d;
  logic  valid_q, valid_d;

  logic served, redirect, accept;

  // Handshake terms use the registered request so a request is only counted
  // as served in a cycle where it is actually visible on the port.
  assign served   = if_req_q && !mem_busy_i;
  assign redirect = branch_flag_i && !stall_i;  // stale operands while stalled
  assign accept   = valid_q && !stall_i;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) state_q <= ST_FETCH;
    else                  state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state (redirect overrides everything, including accept)
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: if (served && req_cnt_q == 2'd3) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_HOLD;
      ST_HOLD:  if (accept) state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
    if (redirect) state_d = ST_FETCH;
  end

  // Datapath next state: pc, counters and byte assembly.
  always_comb begin
    pc_d       = pc_q;
    req_cnt_d  = req_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    served_d   = served;
    inst_buf_d = inst_buf_q;

    if (served) req_cnt_d = req_cnt_q + 2'd1;

    if (served_q) begin
      inst_buf_d[{rcv_cnt_q, 3'b000} +: MemByteBus] = mem_din_i;
      rcv_cnt_d = rcv_cnt_q + 2'd1;
    end

    if (redirect) begin
      // Clearing served_d drops the byte still in flight.
      pc_d      = branch_target_addr_i;
      req_cnt_d = 2'd0;
      rcv_cnt_d = 2'd0;
      served_d  = 1'b0;
    end else if (accept) begin
      pc_d      = pc_q + 32'd4;
      req_cnt_d = 2'd0;
      rcv_cnt_d = 2'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, computed from the next state and registered
  // ---------------------------------------------------------------------------
  always_comb begin
    if_req_d  = (state_d == ST_FETCH);
    valid_d   = (state_d == ST_HOLD);
    if_addr_d = if_addr_q;
    pc_o_d    = pc_o_q;
    inst_d    = inst_q;
    if (state_d == ST_FETCH) if_addr_d = pc_d + {30'd0, req_cnt_d};
    if (state_d == ST_HOLD) begin
      pc_o_d = pc_d;
      inst_d = inst_buf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc_q      <= RESET_PC;
      req_cnt_q <= 2'd0;
      rcv_cnt_q <= 2'd0;
      served_q  <= 1'b0;
      if_req_q  <= 1'b0;
      if_addr_q <= ZeroWord;
      pc_o_q    <= ZeroWord;
      inst_q    <= ZeroWord;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      req_cnt_q <= req_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
      served_q  <= served_d;
      if_req_q  <= if_req_d;
      if_addr_q <= if_addr_d;
      pc_o_q    <= pc_o_d;
      inst_q    <= inst_d;
      valid_q   <= valid_d;
    end
  end

  // NOTE: the assembly buffer is deliberately left without reset: all four
  // lanes are rewritten before it can reach inst_o, which has its own reset.
  always_ff @(posedge clk) begin
    inst_buf_q <= inst_buf_d;
  end

  assign if_req_o     = if_req_q;
  assign if_addr_o    = if_addr_q;
  assign pc_o         = pc_o_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Drives the fetch stage with directed scenarios followed by random busy /
// stall / redirect / reset traffic. A byte-count model of the fetch protocol
// predicts the outputs every cycle; literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_addr_i;
  logic        mem_busy_i;
  logic [7:0]  mem_din_i;
  logic        if_req_o;
  logic [31:0] if_addr_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall_i              (stall_i),
    .branch_flag_i        (branch_flag_i),
    .branch_target_addr_i (branch_target_addr_i),
    .mem_busy_i           (mem_busy_i),
    .mem_din_i            (mem_din_i),
    .if_req_o             (if_req_o),
    .if_addr_o            (if_addr_o),
    .pc_o                 (pc_o),
    .inst_o               (inst_o),
    .inst_valid_o         (inst_valid_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Memory contents: fixed bytes at 0..3, an address hash elsewhere.
  function automatic logic [7:0] mem_at(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  // Model: pc of the instruction being fetched, bytes requested/received so far.
  logic [31:0] m_pc       = RESET_PC;
  int          m_nreq     = 0;
  int          m_nrcv     = 0;
  logic        m_pending  = 1'b0;
  logic [31:0] m_pend_addr = '0;
  logic        m_rst_seen = 1'b1;
  logic [7:0]  m_bytes [4];

  function automatic logic exp_req();
    return !m_rst_seen && (m_nreq < 4);
  endfunction

  function automatic logic exp_valid();
    return (m_nrcv == 4);
  endfunction

  task automatic compare();
    check("if_req_o", {31'd0, if_req_o}, {31'd0, exp_req()});
    check("inst_valid_o", {31'd0, inst_valid_o}, {31'd0, exp_valid()});
    if (exp_req()) check("if_addr_o", if_addr_o, m_pc + 32'(m_nreq));
    if (exp_valid()) begin
      check("pc_o", pc_o, m_pc);
      check("inst_o", inst_o, {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
    end
    if (m_rst_seen) begin
      check("rst_if_addr_o", if_addr_o, 32'd0);
      check("rst_pc_o", pc_o, 32'd0);
      check("rst_inst_o", inst_o, 32'd0);
    end
  endtask

  // One clock cycle: drive inputs (at negedge), advance model on the edge,
  // compare on the following negedge.
  task automatic step(input logic r, input logic b, input logic s, input logic br,
                      input logic [31:0] tgt);
    logic        req_now, v_now, served;
    logic [31:0] addr_now;
    rst                  = r;
    mem_busy_i           = b;
    stall_i              = s;
    branch_flag_i        = br;
    branch_target_addr_i = tgt;
    mem_din_i            = m_pending ? mem_at(m_pend_addr) : 8'($urandom);
    req_now  = exp_req();
    v_now    = exp_valid();
    addr_now = m_pc + 32'(m_nreq);
    @(posedge clk);
    if (r) begin
      m_pc = RESET_PC; m_nreq = 0; m_nrcv = 0; m_pending = 1'b0; m_rst_seen = 1'b1;
    end else begin
      served = req_now && !b;
      if (m_pending) begin
        m_bytes[m_nrcv] = mem_din_i;
        m_nrcv++;
      end
      if (br && !s) begin
        m_pc = tgt; m_nreq = 0; m_nrcv = 0; m_pending = 1'b0;
      end else if (v_now && !s) begin
        m_pc = m_pc + 32'd4; m_nreq = 0; m_nrcv = 0; m_pending = 1'b0;
      end else begin
        if (served) m_nreq++;
        m_pending   = served;
        m_pend_addr = addr_now;
      end
      m_rst_seen = 1'b0;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    logic        r, b, s, br;
    logic [31:0] tgt;

    // Reset, then basic fetch of 13 05 10 00 from address 0.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check("lit_rst_req", {31'd0, if_req_o}, 32'd0);
    check("lit_rst_valid", {31'd0, inst_valid_o}, 32'd0);
    idle(1);  check("lit_c0_addr", if_addr_o, 32'd0);
    check("lit_c0_req", {31'd0, if_req_o}, 32'd1);
    idle(1);  check("lit_c1_addr", if_addr_o, 32'd1);
    idle(1);  check("lit_c2_addr", if_addr_o, 32'd2);
    idle(1);  check("lit_c3_addr", if_addr_o, 32'd3);
    idle(1);  check("lit_c4_req", {31'd0, if_req_o}, 32'd0);
    idle(1);  check("lit_c5_valid", {31'd0, inst_valid_o}, 32'd1);
    check("lit_c5_inst", inst_o, 32'h0010_0513);
    check("lit_c5_pc", pc_o, 32'd0);
    idle(1);  check("lit_c6_addr", if_addr_o, 32'd4);

    // Busy on the second request: address 5 presented twice, valid one cycle late.
    idle(1);  check("lit_busy_f1_addr", if_addr_o, 32'd5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    check("lit_busy_f2_addr", if_addr_o, 32'd5);
    idle(3);  check("lit_busy_f5_valid", {31'd0, inst_valid_o}, 32'd0);
    idle(1);  check("lit_busy_f6_valid", {31'd0, inst_valid_o}, 32'd1);
    check("lit_busy_inst", inst_o, 32'h5D5C_5F5E);
    check("lit_busy_pc", pc_o, 32'd4);

    // Stall for three cycles while valid.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      check("lit_stall_req", {31'd0, if_req_o}, 32'd0);
      check("lit_stall_pc", pc_o, 32'd4);
      check("lit_stall_inst", inst_o, 32'h5D5C_5F5E);
    end
    idle(1);  check("lit_unstall_addr", if_addr_o, 32'd8);

    // Redirect while byte 2 is in flight.
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1000);
    check("lit_redir_addr", if_addr_o, 32'h0000_1000);
    check("lit_redir_valid", {31'd0, inst_valid_o}, 32'd0);
    idle(5);
    check("lit_redir_pc", pc_o, 32'h0000_1000);
    check("lit_redir_inst", inst_o, 32'h4948_4B4A);

    // Redirect and accept in the same cycle: target wins over pc+4.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2000);
    check("lit_redir_acc_addr", if_addr_o, 32'h0000_2000);
    idle(5);
    check("lit_redir_acc_valid", {31'd0, inst_valid_o}, 32'd1);
    // Redirect under stall is ignored.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3000);
    check("lit_stall_br_valid", {31'd0, inst_valid_o}, 32'd1);
    check("lit_stall_br_pc", pc_o, 32'h0000_2000);
    idle(1);  check("lit_stall_br_next", if_addr_o, 32'h0000_2004);

    // Reset mid-fetch (req_cnt = 2).
    idle(2);
    check("lit_mid_addr", if_addr_o, 32'h0000_2006);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check("lit_midrst_req", {31'd0, if_req_o}, 32'd0);
    check("lit_midrst_addr", if_addr_o, 32'd0);
    idle(1);  check("lit_restart_addr", if_addr_o, RESET_PC);

    // pc wrap: instruction at 0xFFFF_FFFC is followed by address 0.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("lit_wrap_addr", if_addr_o, 32'hFFFF_FFFC);
    idle(5);
    check("lit_wrap_pc", pc_o, 32'hFFFF_FFFC);
    idle(1);  check("lit_wrap_next", if_addr_o, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 399) == 0);
      b  = ($urandom_range(0, 9) < 3);
      s  = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFFC;
        1:       tgt = $urandom;
        2:       tgt = $urandom & 32'h0000_FFFF;
        default: tgt = 32'hFFFF_FFFE;
      endcase
      step(r, b, s, br, tgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage. Assembles 32-bit little-endian instructions from the byte-wide unified memory port and presents pc/instruction to the IF/ID register, which feeds the decode stage. Applies the decoder's branch/jump redirect and honours pipeline stall. Shares the memory port with the MEM stage through an external arbiter that signals busy.

## Interface
- `RESET_PC`, default 32'h0000_0000: pc loaded on reset.
- `clk` input 1: clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `stall_i` input 1: downstream (IF/ID) not ready; holds presented instruction.
- `branch_flag_i` input 1: redirect request from decode.
- `branch_target_addr_i` input 32: redirect pc.
- `mem_busy_i` input 1: arbiter serving MEM stage this cycle; fetch request not served.
- `mem_din_i` input 8: read byte, valid the cycle after a served request.
- `if_req_o` output 1: fetch read request.
- `if_addr_o` output 32: byte address of request.
- `pc_o` output 32: address of presented instruction.
- `inst_o` output 32: presented instruction.
- `inst_valid_o` output 1: `pc_o`/`inst_o` valid.

## Operation
- States: FETCH (byte counter `req_cnt` 0..3, receive counter `rcv_cnt` 0..3), DRAIN (last byte in flight), HOLD (instruction presented).
- Request served in cycle t iff `if_req_o && !mem_busy_i` at t. Registered `served` bit qualifies `mem_din_i` at t+1. Unserved byte: same address re-presented next cycle. Unqualified data ignored.
- FETCH: `if_req_o`=1, `if_addr_o`=pc+`req_cnt`. Each served request increments `req_cnt`. Each qualified byte goes to lane `rcv_cnt` of `inst_buf` (byte0→[7:0] … byte3→[31:24]) and increments `rcv_cnt`. Once byte 3 is served: `if_req_o`=0, go to DRAIN.
- DRAIN: capture byte 3, go to HOLD. `inst_valid_o`=1, `inst_o`=`inst_buf`, `pc_o`=pc.
- HOLD: outputs stable while `stall_i`=1. Accept = `inst_valid_o && !stall_i`. On accept: pc ← pc+4 (32-bit wrap, 32'hFFFF_FFFC→0), counters cleared, go to FETCH with `inst_valid_o`=0.
- Redirect = `branch_flag_i && !stall_i`. Takes effect in any state: pc ← `branch_target_addr_i`, counters and `served` cleared, `inst_valid_o` ← 0, go to FETCH. A byte returning the next cycle is discarded.
- Redirect and accept in the same cycle: redirect wins; pc+4 is not applied.
- `branch_flag_i` with `stall_i`=1: ignored, because decode operands may be stale.
- Target low bits are not checked. A misaligned target is fetched bytewise as given.
- Reset values: pc=`RESET_PC`, state FETCH, counters 0, `served`=0, `if_req_o`=0, `if_addr_o`=0, `pc_o`=0, `inst_o`=0, `inst_valid_o`=0. Reset has priority over all inputs, including mid-fetch and HOLD.

## Timing
- c0 = first cycle after the edge with `rst`=0. Requests: c0 pc, c1 pc+1, c2 pc+2, c3 pc+3. Bytes arrive c1..c4. `inst_valid_o`=1 from c5.
- Fetch latency: 5 cycles from first request to valid, plus 1 per busy cycle.
- With no busy and no stall, throughput is 6 cycles/instruction. The next request issues the cycle after accept.
- Redirect in cycle cb: at cb+1 `if_req_o`=1, `if_addr_o`=target, `inst_valid_o`=0.
- Outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared defines header: state encodings, `ZeroWord`, `RstEnable`, `InstAddrBus`/`InstBus` widths, `MemByteBus` (7:0).
- `inst_buf`, counters and FSM are one module. No sub-module: byte assembly is a 4-lane register written by `rcv_cnt`.

## Test plan
- Reset release with memory 0x00..0x03 = 13 05 10 00, no busy → `if_addr_o` 0,1,2,3 in c0..c3; c5 `inst_valid_o`=1, `inst_o`=32'h0010_0513, `pc_o`=0; accept → c6 `if_addr_o`=4.
- `mem_busy_i`=1 in c1 only → address 1 held two cycles, valid at c6, `inst_o` unchanged.
- `stall_i`=1 for 3 cycles while valid → `pc_o`/`inst_o` stable; `if_req_o`=0; pc+4 fetch starts the cycle after `stall_i` falls.
- Redirect to 32'h0000_1000 while byte 2 is in flight → next cycle `if_addr_o`=32'h1000, in-flight byte discarded, next valid has `pc_o`=32'h1000 with bytes from 0x1000.
- Redirect and accept in the same cycle; redirect with `stall_i`=1 → first: pc=target, not pc+4; second: ignored, pc+4 path proceeds.
- `rst` asserted mid-fetch (req_cnt=2) → next cycle all outputs 0; after release, fetch restarts at `RESET_PC`.
